dot_product: RTL and testbench
==============================

// Module: dot_product
// PURPOSE
//  Attention-score stage: takes one Q row and one K row (DIM signed Q0.7 elements each) and computes
//  s = sat((q.k)/sqrt(DIM)) as a signed SCORE_QT (fixed point, 5 fractional bits).
//  Carries the paired V row alongside unchanged, so downstream softmax/PV stages receive {s, v} together.
//  Valid/ready streaming block between the Q/K/V fetch buffers and the softmax stage.
// PARAMETERS
//  DIM        `MAX_EMBEDDING_DIM (64)  elements per vector
//  ELEM_W     `INTEGER_WIDTH (8)       element width, signed Q0.7
//  SCORE_W    13                       s_out width (SCORE_QT)
//  SHIFT      12                       raw-sum to score shift: 14 product frac bits - 5 score frac bits + 3 for /sqrt(64)
//  SCORE_MAX  127                      upper saturation bound
//  SCORE_MIN  -128                     lower saturation bound
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   reset, asynchronous, active-low
//  Q_vld_in   in   1                   q_in valid
//  K_vld_in   in   1                   k_in valid
//  V_vld_in   in   1                   v_in valid
//  Q_rdy_out  out  1                   block can accept Q
//  K_rdy_out  out  1                   block can accept K
//  V_rdy_out  out  1                   block can accept V
//  q_in       in   Q_VECTOR_T          DIM x ELEM_W signed
//  k_in       in   K_VECTOR_T          DIM x ELEM_W signed
//  v_in       in   V_VECTOR_T          DIM x ELEM_W, passed through
//  vld_out    out  1                   s_out/v_out valid
//  rdy_in     in   1                   downstream ready
//  s_out      out  SCORE_QT (13)       signed score
//  v_out      out  V_VECTOR_T          V row paired with s_out
// BEHAVIOUR
//  - Reset (rst=0, async): all stage valids = 0, vld_out = 0, s_out = 0, v_out = 0. Rdy outputs are 1 once rst=1.
//  - Input join:
//    - Q_rdy_out = K_rdy_out = V_rdy_out = (stage1 empty) | (stage1 advancing).
//    - Ready never depends on any *_vld_in.
//    - A transfer occurs on a clk edge where Q_vld_in & K_vld_in & V_vld_in & ready are all 1.
//    - A partial valid set is ignored; nothing is consumed.
//  - Pipeline: 3 register stages, latency 3 cycles from accept edge to vld_out=1 (with rdy_in=1).
//    - Throughput 1 vector pair/cycle.
//    - S1: DIM products p[i] = q[i]*k[i] (2*ELEM_W signed).
//    - S2: S = sum p[i], signed, width 2*ELEM_W + clog2(DIM), no overflow possible.
//    - S3: scale and saturate, registered into s_out.
//  - Scale (default): t = S / 2^SHIFT, truncated toward zero (negative S: add 2^SHIFT-1 before >>>).
//  - Saturate: s_out = clamp(t, SCORE_MIN, SCORE_MAX), sign-extended to SCORE_W.
//  - v_in travels with its q/k pair through all 3 stages.
//  - Backpressure: each stage advances iff downstream stage empty or advancing.
//    - vld_out=1 with rdy_in=0 holds s_out, v_out and vld_out stable until the handshake.
//    - No data dropped or duplicated.
//  - Output handshake completes on an edge with vld_out & rdy_in.
//    - A new result may appear the same edge (bubble-free).
//  - Reset mid-operation flushes all in-flight data; no output appears for inputs accepted before reset.
// CONFIGURATION
//  DOT_PRODUCT_RND_EN:
//    - Defined: scaling rounds to nearest, ties away from zero: t = sign(S)*((|S| + 2^(SHIFT-1)) >> SHIFT).
//    - Undefined (default): truncate toward zero as above.
//    - Saturation and latency are identical in both builds.
// TESTING
//  1. all q=k=127 -> S=1032256, t=252 -> s_out=127 (saturate high), 3 cycles after accept.
//  2. all q=127, k=-128 -> S=-1040384 -> s_out=-128 (saturate low).
//  3. q[0]=k[0]=100, rest 0 -> S=10000 -> s_out=2 (RND_EN: 2); q[0]=k[0]=64 -> s_out=1.
//  4. q[0]=64, k[0]=-63 -> S=-4032 -> s_out=0 (toward zero; RND_EN: -1); v_out equals v_in of same beat.
//  5. Stream 10 random pairs back-to-back while toggling rdy_in:
//     - results in order, match golden trunc0(S/4096) clamped.
//     - outputs stable while stalled.
//     - only K_vld_in=1 -> no accept.
//  6. Assert rst=0 with 2 beats in flight -> vld_out=0, s_out=0 immediately; no stale outputs after release.

Source files
------------

// File: rtl/dot_product.sv
// rtl/dot_product.sv - attention-score dot product with paired V row pass-through
//
// Purpose:
//   Joins one Q row, one K row and one V row, then computes
//   s = sat((q.k) / sqrt(DIM)) as a signed fixed-point score with 5 fractional bits.
//   The V row travels alongside its q/k pair, so {s, v} reach the softmax stage together.
//   The pipeline has three register stages:
//     S1 element products, S2 sum, S3 scale/saturate.
//   Each stage advances when the stage below it is empty or advancing.
//
// Configuration:
//   DOT_PRODUCT_RND_EN  defined   -> scale rounds to nearest, ties away from zero
//                       undefined -> scale truncates toward zero (default)
//
// Ports:
//   clk                              clock
//   rst                              asynchronous active-low reset
//   Q_vld_in/K_vld_in/V_vld_in       input valids; a beat transfers only when all three are set
//   Q_rdy_out/K_rdy_out/V_rdy_out    common input ready (stage 1 empty or advancing)
//   q_in/k_in                        DIM signed Q0.7 elements, element i at [i*ELEM_W +: ELEM_W]
//   v_in                             DIM x ELEM_W V row, passed through untouched
//   vld_out/rdy_in                   output handshake
//   s_out                            signed score, SCORE_W bits
//   v_out                            V row paired with s_out
module dot_product #(
  parameter int DIM       = 64,
  parameter int ELEM_W    = 8,
  parameter int SCORE_W   = 13,
  parameter int SHIFT     = 12,
  parameter int SCORE_MAX = 127,
  parameter int SCORE_MIN = -128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Q_vld_in,
  input  logic                      K_vld_in,
  input  logic                      V_vld_in,
  output logic                      Q_rdy_out,
  output logic                      K_rdy_out,
  output logic                      V_rdy_out,
  input  logic [DIM*ELEM_W-1:0]     q_in,
  input  logic [DIM*ELEM_W-1:0]     k_in,
  input  logic [DIM*ELEM_W-1:0]     v_in,
  output logic                      vld_out,
  input  logic                      rdy_in,
  output logic signed [SCORE_W-1:0] s_out,
  output logic [DIM*ELEM_W-1:0]     v_out
);

  localparam int PROD_W = 2 * ELEM_W;
  localparam int SUM_W  = PROD_W + $clog2(DIM);
  localparam int VEC_W  = DIM * ELEM_W;

  // Scale arithmetic is carried one bit wider than the sum so that negating
  // the most negative sum cannot overflow.
  localparam logic signed [SUM_W:0] SMAX = (SUM_W+1)'(SCORE_MAX);
  localparam logic signed [SUM_W:0] SMIN = (SUM_W+1)'(SCORE_MIN);

  logic                      vld1, vld2;
  logic signed [PROD_W-1:0]  p1 [DIM];
  logic [VEC_W-1:0]          v1, v2;
  logic signed [SUM_W-1:0]   sum2;

  logic                      adv1, adv2, adv3, accept;
  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W:0]     t_c;
  logic signed [SCORE_W-1:0] sat_c;

  // Ready is computed from the stage valids and rdy_in alone, never from the input valids.
  assign adv3      = !vld_out || rdy_in;
  assign adv2      = !vld2 || adv3;
  assign adv1      = !vld1 || adv2;
  assign Q_rdy_out = adv1;
  assign K_rdy_out = adv1;
  assign V_rdy_out = adv1;
  assign accept    = Q_vld_in && K_vld_in && V_vld_in && adv1;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < DIM; i++) begin
      sum_c = sum_c + {{(SUM_W-PROD_W){p1[i][PROD_W-1]}}, p1[i]};
    end
  end

  always_comb begin
    logic signed [SUM_W:0] s_ext;
    logic signed [SUM_W:0] mag;
    s_ext = {sum2[SUM_W-1], sum2};
    mag   = '0;
`ifdef DOT_PRODUCT_RND_EN
    // Round on the magnitude, then restore the sign: ties move away from zero.
    mag = sum2[SUM_W-1] ? -s_ext : s_ext;
    mag = (mag + (SUM_W+1)'(1 << (SHIFT-1))) >>> SHIFT;
    t_c = sum2[SUM_W-1] ? -mag : mag;
`else
    // An arithmetic shift floors, so negative sums are biased first to truncate toward zero.
    mag = sum2[SUM_W-1] ? (SUM_W+1)'((1 << SHIFT) - 1) : '0;
    t_c = (s_ext + mag) >>> SHIFT;
`endif
    if (t_c > SMAX) begin
      sat_c = SMAX[SCORE_W-1:0];
    end else if (t_c < SMIN) begin
      sat_c = SMIN[SCORE_W-1:0];
    end else begin
      sat_c = t_c[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld1    <= 1'b0;
      vld2    <= 1'b0;
      vld_out <= 1'b0;
      v1      <= '0;
      v2      <= '0;
      v_out   <= '0;
      sum2    <= '0;
      s_out   <= '0;
      for (int i = 0; i < DIM; i++) begin
        p1[i] <= '0;
      end
    end else begin
      if (adv1) begin
        vld1 <= accept;
      end
      if (accept) begin
        v1 <= v_in;
        for (int i = 0; i < DIM; i++) begin
          p1[i] <= $signed(q_in[i*ELEM_W +: ELEM_W]) * $signed(k_in[i*ELEM_W +: ELEM_W]);
        end
      end
      if (adv2) begin
        vld2 <= vld1;
      end
      if (adv2 && vld1) begin
        sum2 <= sum_c;
        v2   <= v1;
      end
      if (adv3) begin
        vld_out <= vld2;
      end
      if (adv3 && vld2) begin
        s_out <= sat_c;
        v_out <= v2;
      end
    end
  end

endmodule

// File: tb/tb_dot_product.sv
// tb/tb_dot_product.sv - scoreboard bench for dot_product
module tb_dot_product;
  localparam int DIM = 64;
  localparam int EW  = 8;
  localparam int VW  = DIM * EW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Q_vld_in = 1'b0, K_vld_in = 1'b0, V_vld_in = 1'b0;
  logic          Q_rdy_out, K_rdy_out, V_rdy_out;
  logic [VW-1:0] q_in = '0, k_in = '0, v_in = '0;
  logic          vld_out;
  logic          rdy_in = 1'b1;
  logic signed [12:0] s_out;
  logic [VW-1:0] v_out;

  dot_product dut (
    .clk(clk), .rst(rst),
    .Q_vld_in(Q_vld_in), .K_vld_in(K_vld_in), .V_vld_in(V_vld_in),
    .Q_rdy_out(Q_rdy_out), .K_rdy_out(K_rdy_out), .V_rdy_out(V_rdy_out),
    .q_in(q_in), .k_in(k_in), .v_in(v_in),
    .vld_out(vld_out), .rdy_in(rdy_in), .s_out(s_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0]   s;
    logic [VW-1:0] v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer dot product, /sqrt(64) folded into /4096, then clamp.
  function automatic int model(input logic [VW-1:0] q, input logic [VW-1:0] k);
    longint s = 0;
    longint a, t;
    logic [EW-1:0] qe, ke;
    for (int i = 0; i < DIM; i++) begin
      qe = q[i*EW +: EW];
      ke = k[i*EW +: EW];
      s += longint'($signed(qe)) * longint'($signed(ke));
    end
`ifdef DOT_PRODUCT_RND_EN
    a = (s < 0) ? -s : s;
    t = (a + 2048) / 4096;
    if (s < 0) t = -t;
`else
    t = s / 4096;
`endif
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return int'(t);
  endfunction

  // Input ready stimulus: random or forced, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rdy_in = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  bit stalled = 1'b0;
  logic [12:0]   held_s;
  logic [VW-1:0] held_v;
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else if (vld_out) begin
      if (stalled) begin
        chk("stall_s", VW'($unsigned(s_out)), VW'(held_s));
        chk("stall_v", v_out, held_v);
      end
      if (rdy_in) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("s_out", VW'($unsigned(s_out)), VW'(me.s));
          chk("v_out", v_out, me.v);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_s  = s_out;
        held_v  = v_out;
      end
    end else if (stalled) begin
      chk("vld_dropped_in_stall", 0, 1);
      stalled = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [VW-1:0] q, input logic [VW-1:0] k,
                      input logic [VW-1:0] v, input int exp_s);
    exp_t e;
    int   n  = 0;
    bit   ok = 1'b0;
    q_in = q; k_in = k; v_in = v;
    Q_vld_in = 1'b1; K_vld_in = 1'b1; V_vld_in = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = Q_rdy_out;
      if (!ok) begin
        @(posedge clk); #1;
      end
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.s = exp_s[12:0];
      e.v = v;
      sb.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic drop();
    Q_vld_in = 1'b0; K_vld_in = 1'b0; V_vld_in = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", VW'(sb.size()), 0);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [EW-1:0] x);
    logic [VW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*EW +: EW] = x;
    return r;
  endfunction

  initial begin
    logic [VW-1:0] q, k, v;
    int lat, seen;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("reset_vld_out", VW'(vld_out), 0);
    chk("reset_s_out", VW'($unsigned(s_out)), 0);
    chk("reset_v_out", v_out, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rdy_after_reset", VW'({Q_rdy_out, K_rdy_out, V_rdy_out}), VW'(3'b111));
    cycles(1);

    // 1: saturate high, with latency measurement
    v = rand_vec();
    send(fill(8'd127), fill(8'd127), v, 127);
    drop();
    lat = 1;
    while (!vld_out && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", VW'(lat), 3);
    drain();

    // 2: saturate low
    send(fill(8'd127), fill(8'h80), rand_vec(), -128);
    // 3: small positive sums
    q = '0; k = '0; q[7:0] = 8'd100; k[7:0] = 8'd100;
    send(q, k, rand_vec(), 2);
    q[7:0] = 8'd64; k[7:0] = 8'd64;
    send(q, k, rand_vec(), 1);
    // 4: small negative sum, truncate vs round
    q[7:0] = 8'd64; k[7:0] = 8'hC1;
`ifdef DOT_PRODUCT_RND_EN
    send(q, k, rand_vec(), -1);
`else
    send(q, k, rand_vec(), 0);
`endif
    drop();
    drain();

    // 5: random back-to-back stream with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q = rand_vec(); k = rand_vec();
      send(q, k, rand_vec(), model(q, k));
    end
    drop();
    drain();
    rdy_rand = 1'b0; rdy_force = 1'b1;
    cycles(2);

    // Partial valid set must not be consumed
    seen = 0;
    K_vld_in = 1'b1; q_in = rand_vec(); k_in = rand_vec();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vld_out) seen++;
      if (!Q_rdy_out) seen++;
    end
    drop();
    cycles(5);
    chk("partial_no_accept", VW'(seen), 0);

    // 6: reset with beats in flight and one stalled at the output
    rdy_force = 1'b0;
    cycles(1);
    for (int i = 0; i < 3; i++) begin
      q = rand_vec(); k = rand_vec();
      send(q, k, rand_vec(), model(q, k));
    end
    drop();
    cycles(2);
    chk("stalled_before_reset", VW'(vld_out), 1);
    rst = 1'b0;
    #1;
    chk("midreset_vld_out", VW'(vld_out), 0);
    chk("midreset_s_out", VW'($unsigned(s_out)), 0);
    chk("midreset_v_out", v_out, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    rdy_force = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vld_out) seen++;
    end
    chk("no_stale_after_reset", VW'(seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
